tl_ul_port_buffer: RTL
======================

Name: tl_ul_port_buffer

Overview:
- Registered A/D channel buffer for a 32-bit TileLink-UL port.
- Sits directly downstream of the A/D pass-through port adapter: takes its A channel and returns the D channel to it.
- Breaks timing paths between the core-side adapter and the fabric.
- Tracks outstanding requests so upstream logic can detect a quiesced port.

Parameters:
SRC_W, 1, width of a_source/d_source
A_DEPTH, 2, A-channel FIFO entries (1, 2 or 4)
D_DEPTH, 2, D-channel FIFO entries (1, 2 or 4)
MAX_INFLIGHT, 4, max outstanding A requests without D response (1..15)

Ports:
clock  input  1  sole clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_a_valid  input  1  upstream A valid
in_a_ready  output  1  upstream A ready
in_a_bits  input  77+SRC_W  packed {opcode[2:0],param[2:0],size[1:0],source,address[31:0],mask[3:0],data[31:0],corrupt}
out_a_valid  output  1  fabric A valid
out_a_ready  input  1  fabric A ready
out_a_bits  output  77+SRC_W  same packing as in_a_bits
in_d_valid  input  1  fabric D valid
in_d_ready  output  1  fabric D ready
in_d_bits  input  41+SRC_W  packed {opcode[2:0],param[1:0],size[1:0],source,denied,data[31:0],corrupt}
out_d_valid  output  1  upstream D valid
out_d_ready  input  1  upstream D ready
out_d_bits  output  41+SRC_W  same packing as in_d_bits
inflight  output  4  outstanding request count
idle  output  1  inflight==0 and both FIFOs empty

Behaviour:
- Reset (async assert, sync-to-clock deassert is not required):
  - FIFOs empty, pointers 0, inflight=0, idle=1.
  - out_a_valid=0, out_d_valid=0, bits outputs 0.
  - in_a_ready=1, in_d_ready=1.
- Each channel is an independent circular FIFO with read pointer, write pointer and count. Pointers wrap modulo depth.
- Transfer occurs when valid&&ready. Valid must not depend on ready.
- Latency: 1 cycle from in fire to out_valid. out_bits come from the registered head entry.
- Full: in_x_ready=0 when count==depth.
  - Simultaneous push and pop when full is not accepted, because ready is already low.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Empty: out_x_valid=0. out_x_bits hold the last popped value (don't-care).
- In-flight gating:
  - in_a_ready is additionally forced to 0 when inflight + A-FIFO count == MAX_INFLIGHT.
  - This guarantees each accepted A gets D-buffer space downstream.
- inflight update, per cycle:
  - +1 on in_a fire.
  - -1 on out_d fire.
  - Unchanged when both fire in the same cycle.
  - Saturates at MAX_INFLIGHT.
  - An out_d fire with inflight==0 is a protocol error: inflight stays 0 (no underflow).
- Contents pass through verbatim. No field decode except corrupt/denied, which are carried unchanged.
- Reset mid-transfer: all entries discarded, outputs return to reset values immediately.

Optional Feature:
- TL_UL_PORT_BUFFER_FLOW_EN defined:
  - When a FIFO is empty and its output is ready, input passes combinationally to the output in the same cycle (zero latency) without being stored.
  - In that case in_x_ready = out_x_ready || !full.
- Undefined: strictly registered, 1-cycle minimum latency, no combinational in-to-out path.

Test Plan:
- Reset then single Get (opcode 4, address 0x2000_0010, mask 0xF), out_a_ready=1 -> out_a_valid high the next cycle with identical bits; inflight=1, idle=0.
- Hold out_a_ready=0, push 3 requests with A_DEPTH=2 -> first two accepted, in_a_ready=0 on the third; release -> output order 1, 2, then 3.
- Fire 4 A requests with no D responses, MAX_INFLIGHT=4 -> fifth request stalled (in_a_ready=0). One D response (AccessAckData, data 0xDEADBEEF) consumed -> in_a_ready=1, inflight=3.
- Same-cycle in_a fire and out_d fire at inflight=2 -> inflight stays 2. FIFO simultaneous push/pop at count 1 -> count stays 1, data order preserved.
- Assert reset_n=0 with both FIFOs holding 2 entries -> out valids drop immediately, inflight=0, idle=1; no stale entry appears after release.
- With TL_UL_PORT_BUFFER_FLOW_EN, empty FIFO and out_a_ready=1 -> out_a_valid asserted in the same cycle as in_a_valid, bits equal. Without the macro -> 1-cycle delay.

Source files
------------

// File: rtl/tl_ul_port_buffer.sv
// tl_ul_port_buffer: registered A/D channel buffer with outstanding-request tracking for a 32-bit TL-UL port.
// Optional feature macro TL_UL_PORT_BUFFER_FLOW_EN: zero-latency flow-through when a channel FIFO is empty.

module tl_ul_port_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_allow,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits,
    output logic [2:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [2:0]       count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             store_s;
    logic             consume_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Handshake decode; a bypassed beat is popped without ever being stored
    always_comb begin
        empty_s = (count_r == 3'd0);
        full_s  = (count_r == FULL_CNT);
`ifdef TL_UL_PORT_BUFFER_FLOW_EN
        in_ready = in_allow && (out_ready || !full_s);
        if (empty_s) begin
            out_valid = in_valid && in_allow;
            out_bits  = in_bits;
        end else begin
            out_valid = 1'b1;
            out_bits  = mem_r[rd_ptr_r];
        end
`else
        in_ready  = in_allow && !full_s;
        out_valid = !empty_s;
        out_bits  = mem_r[rd_ptr_r];
`endif
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        store_s   = push_s && !(empty_s && pop_s);
        consume_s = pop_s && !empty_s;
        count     = count_r;
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= W'(0);
            end
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= 3'd0;
        end else begin
            if (store_s) begin
                mem_r[wr_ptr_r] <= in_bits;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (consume_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({store_s, consume_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module tl_ul_port_buffer #(
    parameter int SRC_W        = 1,
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_a_valid,
    output logic              in_a_ready,
    input  logic [76+SRC_W:0] in_a_bits,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [76+SRC_W:0] out_a_bits,
    input  logic              in_d_valid,
    output logic              in_d_ready,
    input  logic [40+SRC_W:0] in_d_bits,
    output logic              out_d_valid,
    input  logic              out_d_ready,
    output logic [40+SRC_W:0] out_d_bits,
    output logic [3:0]        inflight,
    output logic              idle
);
    localparam int A_W = 77 + SRC_W;
    localparam int D_W = 41 + SRC_W;
    localparam logic [3:0] MAX_C = 4'(MAX_INFLIGHT);

    logic [3:0] inflight_r;
    logic [2:0] a_count_s;
    logic [2:0] d_count_s;
    logic [4:0] a_load_s;
    logic       a_allow_s;
    logic       a_fire_s;
    logic       d_fire_s;

    // Requests already counted plus those still queued must leave D space for every response
    always_comb begin
        a_load_s  = 5'(inflight_r) + 5'(a_count_s);
        a_allow_s = (a_load_s < 5'(MAX_INFLIGHT));
        a_fire_s  = in_a_valid && in_a_ready;
        d_fire_s  = out_d_valid && out_d_ready;
        inflight  = inflight_r;
        idle      = (inflight_r == 4'd0) && (a_count_s == 3'd0) && (d_count_s == 3'd0);
    end

    tl_ul_port_buffer_fifo #(.W(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_allow  (a_allow_s),
        .in_valid  (in_a_valid),
        .in_ready  (in_a_ready),
        .in_bits   (in_a_bits),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_bits  (out_a_bits),
        .count     (a_count_s)
    );

    tl_ul_port_buffer_fifo #(.W(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_allow  (1'b1),
        .in_valid  (in_d_valid),
        .in_ready  (in_d_ready),
        .in_bits   (in_d_bits),
        .out_valid (out_d_valid),
        .out_ready (out_d_ready),
        .out_bits  (out_d_bits),
        .count     (d_count_s)
    );

    // Outstanding-request counter; saturates high, never underflows on a stray response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= 4'd0;
        end else begin
            case ({a_fire_s, d_fire_s})
                2'b10: begin
                    if (inflight_r < MAX_C) begin
                        inflight_r <= inflight_r + 4'd1;
                    end else begin
                        inflight_r <= inflight_r;
                    end
                end
                2'b01: begin
                    if (inflight_r != 4'd0) begin
                        inflight_r <= inflight_r - 4'd1;
                    end else begin
                        inflight_r <= inflight_r;
                    end
                end
                default: inflight_r <= inflight_r;
            endcase
        end
    end
endmodule
